display_scan_ctrl: RTL
======================

// Module: display_scan_ctrl
// PURPOSE
// Scan scheduler for the 6-digit multiplexed 7-segment display on the timer board.
// Atomically snapshots hours/minutes/seconds through a valid/ack handshake and converts them to segment codes.
// Time-shares the single segment bus across six digit enables, with an anti-ghost blank slot between digits
// and per-digit blink and decimal-point control. Sits between the time counter and the display pins.
// PARAMETERS
// DIGIT_TICKS   50000  clk cycles each digit is driven (DRIVE slot), >=1
// BLANK_TICKS   500    clk cycles all digits off before each digit (BLANK slot), >=1
// BLINK_FRAMES  64     full scan frames per blink half-period, >=1
// PORTS
// clk          in   1  system clock
// rst          in   1  reset, asynchronous, active-low
// hours        in   5  binary 0..23
// minutes      in   6  binary 0..59
// seconds      in   6  binary 0..59
// load         in   1  snapshot request; held high until load_ack
// load_ack     out  1  one-cycle pulse: snapshot taken this cycle
// blink_mask   in   6  bit i=1: digit i blinks
// dp_mask      in   6  bit i=1: decimal point lit on digit i
// digit_block  out  6  active-low one-hot digit enable; bit0 = seconds units
// number       out  8  segment code from the shared segment constants; bit7 = DP
// frame_start  out  1  one-cycle pulse on entry to digit 0 BLANK slot
// BEHAVIOUR
// - Reset (async, rst=0): digit_block=6'b111111, number=SEG_BLANK, load_ack=0, frame_start=0,
//   snapshot=00:00:00, state=BLANK, digit index=0, slot counter=0, blink phase=0, frame counter=0.
// - FSM: BLANK -(BLANK_TICKS cycles)-> DRIVE -(DIGIT_TICKS cycles)-> BLANK of next digit.
// - In BLANK, digit_block=6'b111111 and number=SEG_BLANK.
// - Digit index runs 0..5 and wraps 5->0. The wrap is the frame boundary, and frame_start pulses on the first BLANK cycle of digit 0.
// - Frame period = 6*(BLANK_TICKS+DIGIT_TICKS) cycles.
// - DRIVE digit i: digit_block = ~(1<<i), registered.
//   Digit map: 0=sec units, 1=sec tens, 2=min units, 3=min tens, 4=hr units, 5=hr tens.
//   number[6:0] = code of that BCD digit; number[7] = DP state per dp_mask[i], encoded as the shared constants require.
// - Out of range: snapshot minutes or seconds >59, or hours >23 -> both digits of that field show SEG_DASH.
// - Handshake: the snapshot is taken only on the frame-boundary cycle (the cycle digit index wraps to 0) while load=1.
//   That same cycle load_ack=1. New values are shown from digit 0 of that frame onward.
// - Worst-case latency from load rise to load_ack = one frame period.
// - load already high on the boundary cycle: accepted that cycle.
// - load dropped before a boundary: no snapshot, no ack.
// - load held after ack: treated as a new request at the next boundary.
// - Blink: the frame counter counts frames.
//   On reaching BLINK_FRAMES-1 at a boundary, it clears and the blink phase toggles.
//   Phase=1 and blink_mask[i]=1: digit i DRIVE slot behaves as BLANK (digit_block=6'b111111, number=SEG_BLANK).
//   Slot timing is unchanged.
// - blink_mask and dp_mask are sampled every cycle. Changes take effect at the next DRIVE slot entry and are held for the slot.
// - Reset mid-operation: outputs are at reset values asynchronously. The scan restarts at digit 0 BLANK after release.
// - All outputs are registered. There are no combinational paths from inputs to outputs.
// STRUCTURE
// - Shared package timer_pkg:
//   - SEG_0..SEG_9, SEG_BLANK, SEG_DASH, DIGIT_OFF=6'b111111.
//   - scan_state_t enum {BLANK, DRIVE}.
//   - DIGIT_BLOCK_1..6 enable patterns.
// - Sub-module bin2seg2: 6-bit binary in -> {tens,units} segment codes; range limit is a parameter, out-of-range gives SEG_DASH.
//   Instantiated three times: hours limit 23, minutes and seconds limit 59.
// - The top level holds the FSM, slot and frame counters, snapshot registers, blink logic and output mux.
// TESTING (DIGIT_TICKS=4, BLANK_TICKS=1, BLINK_FRAMES=2, frame=30 cycles)
// 1. Reset and release -> digit_block=111111, number=SEG_BLANK during reset. First DRIVE is digit_block=111110 with SEG_0, 4 cycles.
// 2. load with 12:34:56 -> load_ack pulses once at the boundary. Digits 0..5 show SEG_6,5,4,3,2,1.
//    Next frame shows the same values with no second ack after load drops.
// 3. load with minutes=60, hours=24 -> digits 2,3,4,5 show SEG_DASH; seconds digits normal.
// 4. blink_mask=6'b000011 -> digits 0,1 dark for 2 frames, lit for 2 frames, alternating. Other digits are never dark.
// 5. load rising on the exact boundary cycle -> ack in that same cycle.
//    load pulsed 3 cycles mid-frame -> no ack, display unchanged.
// 6. Reset asserted during digit 3 DRIVE -> outputs at reset values immediately.
//    After release, the scan starts at digit 0 BLANK and shows 00:00:00.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer board display path.
// Contents: 7-segment codes, the DP bit mask, digit-enable patterns, the scan
// state type and small lookup helpers.
// Segment codes are active-low (common-anode drive): bit i = 0 lights segment
// i (a..g in bits 0..6), and bit 7 = 0 lights the decimal point.
package timer_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  // Clearing this bit in a code lights the decimal point.
  localparam logic [7:0] SEG_DP    = 8'h80;

  localparam logic [5:0] DIGIT_OFF     = 6'b111111;
  localparam logic [5:0] DIGIT_BLOCK_1 = 6'b111110;
  localparam logic [5:0] DIGIT_BLOCK_2 = 6'b111101;
  localparam logic [5:0] DIGIT_BLOCK_3 = 6'b111011;
  localparam logic [5:0] DIGIT_BLOCK_4 = 6'b110111;
  localparam logic [5:0] DIGIT_BLOCK_5 = 6'b101111;
  localparam logic [5:0] DIGIT_BLOCK_6 = 6'b011111;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Decimal value 0..9 to segment code; anything else shows a dash.
  function automatic logic [7:0] seg_of_dec(input logic [5:0] dec);
    case (dec)
      6'd0:    return SEG_0;
      6'd1:    return SEG_1;
      6'd2:    return SEG_2;
      6'd3:    return SEG_3;
      6'd4:    return SEG_4;
      6'd5:    return SEG_5;
      6'd6:    return SEG_6;
      6'd7:    return SEG_7;
      6'd8:    return SEG_8;
      6'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

  // Digit index 0..5 to its active-low enable pattern.
  function automatic logic [5:0] digit_block_of(input logic [2:0] idx);
    case (idx)
      3'd0:    return DIGIT_BLOCK_1;
      3'd1:    return DIGIT_BLOCK_2;
      3'd2:    return DIGIT_BLOCK_3;
      3'd3:    return DIGIT_BLOCK_4;
      3'd4:    return DIGIT_BLOCK_5;
      3'd5:    return DIGIT_BLOCK_6;
      default: return DIGIT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_ctrl_bin2seg2.sv
// bin2seg2: converts a 6-bit binary field into two segment codes.
// Ports:
//   value  in  6  binary field value
//   tens   out 8  segment code of the tens digit
//   units  out 8  segment code of the units digit
// A value above LIMIT shows SEG_DASH on both digits. Purely combinational;
// the caller registers the result.
module bin2seg2
  import timer_pkg::*;
#(
  parameter int unsigned LIMIT = 59
) (
  input  logic [5:0] value,
  output logic [7:0] tens,
  output logic [7:0] units
);

  localparam logic [5:0] LIMIT_V = 6'(LIMIT);

  logic [5:0] rem_s;
  logic [5:0] tens_bin_s;

  // Split into tens/units by repeated subtraction (max 6 tens for 63).
  always_comb begin
    rem_s      = value;
    tens_bin_s = 6'd0;
    for (int i = 0; i < 6; i++) begin
      if (rem_s >= 6'd10) begin
        rem_s      = rem_s - 6'd10;
        tens_bin_s = tens_bin_s + 6'd1;
      end else begin
        tens_bin_s = tens_bin_s;
      end
    end
    if (value > LIMIT_V) begin
      tens  = SEG_DASH;
      units = SEG_DASH;
    end else begin
      tens  = seg_of_dec(tens_bin_s);
      units = seg_of_dec(rem_s);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: scan scheduler for the 6-digit multiplexed 7-segment
// display. Snapshots hh:mm:ss at frame boundaries via load/load_ack and
// time-shares the segment bus with a blank slot before each digit.
// Ports:
//   clk          in   1  system clock
//   rst          in   1  asynchronous active-low reset
//   hours        in   5  binary 0..23
//   minutes      in   6  binary 0..59
//   seconds      in   6  binary 0..59
//   load         in   1  snapshot request, held until load_ack
//   load_ack     out  1  one-cycle pulse, snapshot registers updated this cycle
//   blink_mask   in   6  per-digit blink enable
//   dp_mask      in   6  per-digit decimal point
//   digit_block  out  6  active-low one-hot digit enable, bit0 = seconds units
//   number       out  8  segment code, bit7 = DP (active-low)
//   frame_start  out  1  pulse on the first BLANK cycle of digit 0
// Timing: load is sampled on the clock edge that wraps digit 5 -> digit 0;
// load_ack, frame_start and the new snapshot all appear in the cycle after
// that edge, which is the first BLANK cycle of the new frame.
module display_scan_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS  = 50000,
  parameter int unsigned BLANK_TICKS  = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       load,
  output logic       load_ack,
  input  logic [5:0] blink_mask,
  input  logic [5:0] dp_mask,
  output logic [5:0] digit_block,
  output logic [7:0] number,
  output logic       frame_start
);

  localparam int unsigned SLOT_MAX = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int unsigned SLOT_W   = $clog2(SLOT_MAX + 1);
  localparam int unsigned FRAME_W  = $clog2(BLINK_FRAMES + 1);

  localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_TICKS - 1);
  localparam logic [SLOT_W-1:0]  DRIVE_LAST = SLOT_W'(DIGIT_TICKS - 1);
  localparam logic [SLOT_W-1:0]  SLOT_ONE   = SLOT_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

  scan_state_t        state_r, state_s;
  logic [2:0]         digit_idx_r, digit_idx_s;
  logic [SLOT_W-1:0]  slot_cnt_r, slot_cnt_s;
  logic [FRAME_W-1:0] frame_cnt_r, frame_cnt_s;
  logic               blink_phase_r, blink_phase_s;
  logic               wrap_s, drive_entry_s;

  logic [4:0] hours_r;
  logic [5:0] minutes_r, seconds_r;

  logic [7:0] sec_units_s, sec_tens_s, min_units_s, min_tens_s, hr_units_s, hr_tens_s;
  logic [7:0] code_s;
  logic       blink_bit_s, dp_bit_s;

  logic [5:0] digit_block_r, digit_block_s;
  logic [7:0] number_r, number_s;
  logic       load_ack_r, frame_start_r;

  bin2seg2 #(.LIMIT(32'd59)) u_sec (.value(seconds_r),        .tens(sec_tens_s), .units(sec_units_s));
  bin2seg2 #(.LIMIT(32'd59)) u_min (.value(minutes_r),        .tens(min_tens_s), .units(min_units_s));
  bin2seg2 #(.LIMIT(32'd23)) u_hr  (.value({1'b0, hours_r}),  .tens(hr_tens_s),  .units(hr_units_s));

  // Slot sequencer: BLANK -> DRIVE -> BLANK of next digit; wrap 5->0 is the frame boundary.
  always_comb begin
    state_s       = state_r;
    digit_idx_s   = digit_idx_r;
    slot_cnt_s    = slot_cnt_r + SLOT_ONE;
    wrap_s        = 1'b0;
    drive_entry_s = 1'b0;
    case (state_r)
      BLANK: begin
        if (slot_cnt_r == BLANK_LAST) begin
          state_s       = DRIVE;
          slot_cnt_s    = '0;
          drive_entry_s = 1'b1;
        end else begin
          state_s = BLANK;
        end
      end
      DRIVE: begin
        if (slot_cnt_r == DRIVE_LAST) begin
          state_s    = BLANK;
          slot_cnt_s = '0;
          if (digit_idx_r == 3'd5) begin
            digit_idx_s = 3'd0;
            wrap_s      = 1'b1;
          end else begin
            digit_idx_s = digit_idx_r + 3'd1;
          end
        end else begin
          state_s = DRIVE;
        end
      end
      default: begin
        state_s     = BLANK;
        slot_cnt_s  = '0;
        digit_idx_s = 3'd0;
      end
    endcase
  end

  // Blink frame counter: phase toggles every BLINK_FRAMES frame boundaries.
  always_comb begin
    frame_cnt_s   = frame_cnt_r;
    blink_phase_s = blink_phase_r;
    if (wrap_s) begin
      if (frame_cnt_r == FRAME_LAST) begin
        frame_cnt_s   = '0;
        blink_phase_s = ~blink_phase_r;
      end else begin
        frame_cnt_s = frame_cnt_r + FRAME_ONE;
      end
    end else begin
      frame_cnt_s = frame_cnt_r;
    end
  end

  // Select the code and mask bits for the digit about to be driven.
  always_comb begin
    code_s      = SEG_BLANK;
    blink_bit_s = 1'b0;
    dp_bit_s    = 1'b0;
    case (digit_idx_r)
      3'd0: begin code_s = sec_units_s; blink_bit_s = blink_mask[0]; dp_bit_s = dp_mask[0]; end
      3'd1: begin code_s = sec_tens_s;  blink_bit_s = blink_mask[1]; dp_bit_s = dp_mask[1]; end
      3'd2: begin code_s = min_units_s; blink_bit_s = blink_mask[2]; dp_bit_s = dp_mask[2]; end
      3'd3: begin code_s = min_tens_s;  blink_bit_s = blink_mask[3]; dp_bit_s = dp_mask[3]; end
      3'd4: begin code_s = hr_units_s;  blink_bit_s = blink_mask[4]; dp_bit_s = dp_mask[4]; end
      3'd5: begin code_s = hr_tens_s;   blink_bit_s = blink_mask[5]; dp_bit_s = dp_mask[5]; end
      default: begin code_s = SEG_BLANK; blink_bit_s = 1'b0; dp_bit_s = 1'b0; end
    endcase
  end

  // Output pattern: loaded on DRIVE entry and held for the slot, dark in BLANK.
  always_comb begin
    digit_block_s = digit_block_r;
    number_s      = number_r;
    if (state_s == BLANK) begin
      digit_block_s = DIGIT_OFF;
      number_s      = SEG_BLANK;
    end else if (drive_entry_s) begin
      if (blink_phase_r && blink_bit_s) begin
        digit_block_s = DIGIT_OFF;
        number_s      = SEG_BLANK;
      end else begin
        digit_block_s = digit_block_of(digit_idx_r);
        number_s      = dp_bit_s ? (code_s & ~SEG_DP) : code_s;
      end
    end else begin
      digit_block_s = digit_block_r;
      number_s      = number_r;
    end
  end

  // State, counters, snapshot and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= BLANK;
      digit_idx_r   <= 3'd0;
      slot_cnt_r    <= '0;
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
      hours_r       <= 5'd0;
      minutes_r     <= 6'd0;
      seconds_r     <= 6'd0;
      digit_block_r <= DIGIT_OFF;
      number_r      <= SEG_BLANK;
      load_ack_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      digit_idx_r   <= digit_idx_s;
      slot_cnt_r    <= slot_cnt_s;
      frame_cnt_r   <= frame_cnt_s;
      blink_phase_r <= blink_phase_s;
      digit_block_r <= digit_block_s;
      number_r      <= number_s;
      load_ack_r    <= wrap_s & load;
      frame_start_r <= wrap_s;
      if (wrap_s && load) begin
        hours_r   <= hours;
        minutes_r <= minutes;
        seconds_r <= seconds;
      end
    end
  end

  assign digit_block = digit_block_r;
  assign number      = number_r;
  assign load_ack    = load_ack_r;
  assign frame_start = frame_start_r;

endmodule
